// File: rtl/md5_guess_generator_if.sv
// Port bundle for md5_guess_generator: sweep control from the requester, candidate stream to the consumer.
interface md5_guess_generator_if;
   logic         start;
   logic [3:0]   start_len;
   logic [3:0]   stop_len;
   logic         abort;
   logic         en;
   logic [127:0] guess;
   logic [3:0]   guesslen;
   logic         valid;
   logic         busy;
   logic         done;
   logic         err;
   logic [39:0]  count;

   modport master (
      output start, start_len, stop_len, abort, en,
      input  guess, guesslen, valid, busy, done, err, count
   );

   modport slave (
      input  start, start_len, stop_len, abort, en,
      output guess, guesslen, valid, busy, done, err, count
   );
endinterface

// File: rtl/md5_guess_generator.sv
// Brute-force candidate generator: sweeps every string over [CHAR_MIN..CHAR_MAX]
// from start_len to stop_len bytes, one candidate per consumed cycle.
//
// state | meaning
// IDLE  | no sweep; waiting for a valid start
// RUN   | presenting candidates; advance on en
// DONE  | last candidate consumed; outputs hold final values
module md5_guess_generator #(
   parameter logic [7:0] CHAR_MIN = 8'h61,
   parameter logic [7:0] CHAR_MAX = 8'h7a
) (
   input logic                  clk,
   input logic                  rst,
   md5_guess_generator_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state, state_nx;
   logic [127:0] guess_q, guess_nx, odo_guess;
   logic [3:0]   len_q, len_nx, stop_q, stop_nx;
   logic [39:0]  count_q, count_nx;
   logic         err_q, err_nx;
   logic         all_max;
   logic         start_ok;

   // Used bytes set to CHAR_MIN, unused bytes zero.
   function automatic logic [127:0] fill_min(input logic [3:0] n);
      logic [127:0] f;
      f = '0;
      for (int i = 0; i < 16; i++) begin
         if (4'(i) < n) f[127-8*i -: 8] = CHAR_MIN;
      end
      return f;
   endfunction

   // Odometer step; carry out of byte 0 means every used byte was at CHAR_MAX.
   always_comb begin : odometer
      logic carry;
      carry     = 1'b1;
      odo_guess = guess_q;
      for (int i = 15; i >= 0; i--) begin
         if ((4'(i) < len_q) && carry) begin
            if (guess_q[127-8*i -: 8] == CHAR_MAX) begin
               odo_guess[127-8*i -: 8] = CHAR_MIN;
            end else begin
               odo_guess[127-8*i -: 8] = guess_q[127-8*i -: 8] + 8'd1;
               carry = 1'b0;
            end
         end
      end
      all_max = carry;
   end

   assign start_ok = (bus.start_len != 4'd0) && (bus.stop_len != 4'd0) &&
                     (bus.start_len <= bus.stop_len);

   always_comb begin
      state_nx = state;
      guess_nx = guess_q;
      len_nx   = len_q;
      stop_nx  = stop_q;
      count_nx = count_q;
      err_nx   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               if (start_ok) begin
                  state_nx = RUN;
                  len_nx   = bus.start_len;
                  stop_nx  = bus.stop_len;
                  guess_nx = fill_min(bus.start_len);
                  count_nx = '0;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_nx = IDLE;
            end else if (bus.en) begin
               count_nx = count_q + 40'd1;
               if (!all_max) begin
                  guess_nx = odo_guess;
               end else if (len_q < stop_q) begin
                  len_nx   = len_q + 4'd1;
                  guess_nx = fill_min(len_q + 4'd1);
               end else begin
                  state_nx = DONE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         guess_q <= '0;
         len_q   <= '0;
         stop_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         guess_q <= guess_nx;
         len_q   <= len_nx;
         stop_q  <= stop_nx;
         count_q <= count_nx;
         err_q   <= err_nx;
      end
   end

   assign bus.guess    = guess_q;
   assign bus.guesslen = len_q;
   assign bus.valid    = (state == RUN);
   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);
   assign bus.err      = err_q;
   assign bus.count    = count_q;

endmodule

// File: doc/md5_guess_generator.md
MD5_GUESS_GENERATOR -- requirements
Module: md5_guess_generator

Interface
REQ-001 SHALL have parameter CHAR_MIN, default 8'h61, lowest character code in the charset.
REQ-002 SHALL have parameter CHAR_MAX, default 8'h7a, highest character code in the charset; CHAR_MIN < CHAR_MAX is required.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a keyspace sweep.
REQ-006 start_len  in  4  first guess length in bytes (1..15).
REQ-007 stop_len  in  4  last guess length in bytes (1..15).
REQ-008 abort  in  1  terminates a sweep in progress.
REQ-009 en  in  1  downstream advance; the current guess is consumed on a cycle with valid=1 and en=1.
REQ-010 guess  out  128  candidate; byte 0 at [127:120], byte i at [127-8i -: 8]; bytes at index >= guesslen are 8'h00.
REQ-011 guesslen  out  4  byte length of guess.
REQ-012 valid  out  1  guess/guesslen hold a candidate.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  high in DONE.
REQ-015 err  out  1  one-cycle pulse on a rejected start.
REQ-016 count  out  40  number of guesses consumed since the last accepted start.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; valid=busy=(state==RUN), done=(state==DONE).
REQ-018 In IDLE or DONE, start with 1<=start_len<=stop_len<=15 SHALL enter RUN next cycle with guesslen=start_len, every used byte=CHAR_MIN, and count=0.
REQ-019 A start with start_len==0, stop_len==0, or start_len>stop_len SHALL leave state, guess, guesslen and count unchanged and pulse err for exactly one cycle.
REQ-020 start SHALL be ignored in RUN, with no err pulse.
REQ-021 In RUN with en=0, guess, guesslen and count SHALL hold.
REQ-022 In RUN with en=1, count SHALL increment by 1 and guess SHALL advance as an odometer: byte guesslen-1 is least significant; a byte below CHAR_MAX increments by 1; a byte at CHAR_MAX wraps to CHAR_MIN and carries to the next lower index.
REQ-023 When every used byte is CHAR_MAX and guesslen<stop_len, en=1 SHALL set guesslen+1 with all used bytes at CHAR_MIN.
REQ-024 When every used byte is CHAR_MAX and guesslen==stop_len, en=1 SHALL enter DONE next cycle; guess, guesslen and count then hold their final values.
REQ-025 Each candidate SHALL be presented with valid=1 until consumed, so no candidate is skipped or repeated.
REQ-026 The first guess SHALL be valid one cycle after an accepted start; sustained en=1 SHALL yield one new guess per cycle.
REQ-027 abort in RUN SHALL enter IDLE next cycle; guess and count hold; abort has priority over en on the same cycle.
REQ-028 abort outside RUN SHALL have no effect.
REQ-029 count SHALL wrap modulo 2^40 without affecting the sweep.
REQ-030 Output bytes at index >= guesslen SHALL be zero at every cycle, including across a length step.

Reset
REQ-031 rst SHALL take priority over all inputs and, on the next edge, set state=IDLE, guess=0, guesslen=0, count=0 and valid=busy=done=err=0.
REQ-032 rst asserted in RUN SHALL discard the sweep; no guess is presented until a new accepted start.

Verification
REQ-033 CHAR_MIN=8'h61, CHAR_MAX=8'h63; start with start_len=1, stop_len=2; en=1 held -> guesses a,b,c,aa,ab,ac,ba,...,cc; 12 consecutive valid cycles; then done=1 and count=12.
REQ-034 Same parameters; start_len=2, stop_len=2; en toggling 1,0,1,0 -> guess holds on en=0 cycles; sequence aa,ab,ac,ba; count increments only on en=1 cycles.
REQ-035 start with start_len=3, stop_len=2 -> err=1 for one cycle; state stays IDLE; valid=0.
REQ-036 Default parameters; start with start_len=4, stop_len=4; after 3 consumes -> guess[127:96]=32'h61616164 and guess[95:0]=0.
REQ-037 abort and en both high in RUN -> IDLE next cycle; count unchanged. Separately, rst pulsed mid-sweep -> all outputs 0 next cycle; a subsequent start restarts from CHAR_MIN.
REQ-038 Default parameters; start_len=1, stop_len=1; start asserted again in RUN -> ignored; after 26 consumes -> done=1, guess[127:120]=8'h7a.
